// File: rtl/dac_wave_gen.sv
// dac_wave_gen: DDS waveform source feeding the 8-bit serial DAC driver.
// One registered sample per DAC frame, updated in the driver's idle window.
module dac_wave_gen #(
  parameter int PHASE_W   = 16,
  parameter int FRAME_LEN = 255,
  parameter int UPDATE_AT = 128
) (
  input  logic               clk_50M,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] freq_word,
  output logic [7:0]         data_out,
  output logic               sample_tick
);

  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);
  localparam logic [FC_W-1:0] FC_UPD  = FC_W'(UPDATE_AT);

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_SIN = 2'd3
  } wave_e;

  logic [FC_W-1:0]    fc_q, fc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         data_q, data_d;
  logic               tick_q, tick_d;
  logic               upd;

  logic [7:0] p;
  logic [7:0] tri_base;
  logic [5:0] sin_idx;
  logic [7:0] sin_mag;
  logic [7:0] wave;

  // Quarter-wave sine magnitude, sampled at bin centres
  function automatic logic [6:0] qsin(input logic [5:0] k);
    logic [6:0] v;
    case (k)
      6'd0:  v = 7'd2;
      6'd1:  v = 7'd5;
      6'd2:  v = 7'd8;
      6'd3:  v = 7'd11;
      6'd4:  v = 7'd14;
      6'd5:  v = 7'd17;
      6'd6:  v = 7'd20;
      6'd7:  v = 7'd23;
      6'd8:  v = 7'd26;
      6'd9:  v = 7'd29;
      6'd10: v = 7'd32;
      6'd11: v = 7'd35;
      6'd12: v = 7'd38;
      6'd13: v = 7'd41;
      6'd14: v = 7'd44;
      6'd15: v = 7'd47;
      6'd16: v = 7'd50;
      6'd17: v = 7'd53;
      6'd18: v = 7'd56;
      6'd19: v = 7'd58;
      6'd20: v = 7'd61;
      6'd21: v = 7'd64;
      6'd22: v = 7'd67;
      6'd23: v = 7'd69;
      6'd24: v = 7'd72;
      6'd25: v = 7'd74;
      6'd26: v = 7'd77;
      6'd27: v = 7'd79;
      6'd28: v = 7'd82;
      6'd29: v = 7'd84;
      6'd30: v = 7'd86;
      6'd31: v = 7'd89;
      6'd32: v = 7'd91;
      6'd33: v = 7'd93;
      6'd34: v = 7'd95;
      6'd35: v = 7'd97;
      6'd36: v = 7'd99;
      6'd37: v = 7'd101;
      6'd38: v = 7'd103;
      6'd39: v = 7'd105;
      6'd40: v = 7'd106;
      6'd41: v = 7'd108;
      6'd42: v = 7'd110;
      6'd43: v = 7'd111;
      6'd44: v = 7'd113;
      6'd45: v = 7'd114;
      6'd46: v = 7'd115;
      6'd47: v = 7'd117;
      6'd48: v = 7'd118;
      6'd49: v = 7'd119;
      6'd50: v = 7'd120;
      6'd51: v = 7'd121;
      6'd52: v = 7'd122;
      6'd53: v = 7'd123;
      6'd54: v = 7'd124;
      6'd55: v = 7'd124;
      6'd56: v = 7'd125;
      6'd57: v = 7'd125;
      6'd58: v = 7'd126;
      6'd59: v = 7'd126;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  // Frame counter free-runs so frame alignment survives en low
  always_comb begin
    fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FC_W'(1);
  end

  assign upd = en && (fc_q == FC_UPD);

  // Map the top phase byte to a sample of the selected waveform
  always_comb begin
    p        = phase_q[PHASE_W-1 -: 8];
    tri_base = {p[6:0], 1'b0};
    sin_idx  = p[6] ? ~p[5:0] : p[5:0];
    sin_mag  = {1'b0, qsin(sin_idx)};
    wave     = p;
    case (wave_e'(wave_sel))
      WAVE_SAW: wave = p;
      WAVE_TRI: wave = p[7] ? ~tri_base : tri_base;
      WAVE_SQR: wave = p[7] ? 8'h00 : 8'hFF;
      WAVE_SIN: wave = p[7] ? 8'd127 - sin_mag
                            : 8'd128 + sin_mag;
      default:  wave = p;
    endcase
  end

  // Advance phase and latch a new sample only on the update slot
  always_comb begin
    phase_d = phase_q;
    data_d  = data_q;
    tick_d  = 1'b0;
    if (upd) begin
      phase_d = phase_q + freq_word;
      data_d  = wave;
      tick_d  = 1'b1;
    end
  end

  // State registers; reset parks the output at midscale
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      fc_q    <= '0;
      phase_q <= '0;
      data_q  <= 8'h80;
      tick_q  <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      tick_q  <= tick_d;
    end
  end

  assign data_out    = data_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: directed and random checks of the DDS sample source
// against an arithmetic waveform model.
module tb_dac_wave_gen;

  localparam int PW = 16;
  localparam int FL = 255;
  localparam int UA = 128;

  logic          clk_50M = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    wave_sel = 2'd0;
  logic [PW-1:0] freq_word = '0;
  logic [7:0]    data_out;
  logic          sample_tick;

  int n_pass = 0;
  int n_total = 0;
  int m_phase = 0;
  int lut [64];
  int nt, nch;
  logic [7:0] held;

  logic [7:0] tri_exp [4] = '{8'h00, 8'h80, 8'hFF, 8'h7F};
  logic [7:0] sqr_exp [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [7:0] sin_exp [4] = '{8'h82, 8'hFF, 8'h7D, 8'h00};

  dac_wave_gen #(
    .PHASE_W(PW),
    .FRAME_LEN(FL),
    .UPDATE_AT(UA)
  ) dut (
    .clk_50M(clk_50M),
    .rst(rst),
    .en(en),
    .wave_sel(wave_sel),
    .freq_word(freq_word),
    .data_out(data_out),
    .sample_tick(sample_tick)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic int wave(input int ph, input int sel);
    int p;
    int i;
    p = (ph >> (PW - 8)) & 255;
    i = p % 64;
    if (sel == 0) return p;
    if (sel == 1) return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
    if (sel == 2) return (p < 128) ? 255 : 0;
    if (p < 64)  return 128 + lut[i];
    if (p < 128) return 128 + lut[63 - i];
    if (p < 192) return 127 - lut[i];
    return 127 - lut[63 - i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic get_sample(input string tag, input int gap,
                            input int want);
    int n;
    int exp;
    logic [7:0] h;
    bit stable;
    n = 0;
    h = data_out;
    stable = 1'b1;
    do begin
      @(negedge clk_50M);
      n++;
      if (!sample_tick && data_out !== h) stable = 1'b0;
    end while (!sample_tick && n < 2 * FL);
    check({tag, "_tick"}, {31'd0, sample_tick}, 32'd1);
    check({tag, "_hold"}, {31'd0, stable}, 32'd1);
    if (gap != 0) check({tag, "_gap"}, n, gap);
    exp = wave(m_phase, int'(wave_sel));
    check({tag, "_data"}, {24'd0, data_out}, exp);
    if (want >= 0) check({tag, "_const"}, {24'd0, data_out}, want);
    m_phase = (m_phase + int'(freq_word)) % (1 << PW);
  endtask

  task automatic do_reset(input logic [1:0] sel, input logic [PW-1:0] fw);
    @(negedge clk_50M);
    rst = 1'b1;
    wave_sel = sel;
    freq_word = fw;
    @(negedge clk_50M);
    rst = 1'b0;
    m_phase = 0;
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      lut[k] = $rtoi(127.0 * $sin(3.14159265358979 * (k + 0.5) / 128.0) + 0.5);

    repeat (3) @(negedge clk_50M);
    check("por_data", {24'd0, data_out}, 32'h80);
    check("por_tick", {31'd0, sample_tick}, 32'd0);
    en = 1'b1;
    wave_sel = 2'd0;
    freq_word = 16'h3C00;
    rst = 1'b0;
    m_phase = 0;
    get_sample("por_first", UA + 1, 8'h00);
    get_sample("saw3c", FL, 8'h3C);

    repeat (200 - (UA + 1)) @(negedge clk_50M);
    #3 rst = 1'b1;
    #1;
    check("midrst_data", {24'd0, data_out}, 32'h80);
    check("midrst_tick", {31'd0, sample_tick}, 32'd0);
    wave_sel = 2'd0;
    freq_word = 16'h0100;
    @(negedge clk_50M);
    rst = 1'b0;
    m_phase = 0;
    get_sample("rst_first", UA + 1, 8'h00);
    for (int i = 1; i < 8; i++) get_sample("saw", FL, i);

    do_reset(2'd1, 16'h4000);
    for (int i = 0; i < 6; i++)
      get_sample("tri", (i == 0) ? UA + 1 : FL, tri_exp[i % 4]);
    do_reset(2'd2, 16'h4000);
    for (int i = 0; i < 6; i++)
      get_sample("sqr", (i == 0) ? UA + 1 : FL, sqr_exp[i % 4]);
    do_reset(2'd3, 16'h4000);
    for (int i = 0; i < 6; i++)
      get_sample("sin4", (i == 0) ? UA + 1 : FL, sin_exp[i % 4]);

    held = data_out;
    en = 1'b0;
    nt = 0;
    nch = 0;
    repeat (3 * FL) begin
      @(negedge clk_50M);
      if (sample_tick) nt++;
      if (data_out !== held) nch++;
    end
    check("dis_ticks", nt, 0);
    check("dis_hold", nch, 0);
    en = 1'b1;
    get_sample("en_resume", FL, -1);
    get_sample("en_next", FL, -1);

    repeat (FL - (UA + 1) + 10) @(negedge clk_50M);
    held = data_out;
    wave_sel = 2'd1;
    freq_word = 16'h2345;
    nt = 0;
    nch = 0;
    repeat (UA - 1 - 10) begin
      @(negedge clk_50M);
      if (sample_tick) nt++;
      if (data_out !== held) nch++;
    end
    check("chg_ticks", nt, 0);
    check("chg_hold", nch, 0);
    get_sample("chg_apply", 2, -1);
    get_sample("chg_next", FL, -1);

    for (int i = 0; i < 12; i++) begin
      wave_sel = 2'($urandom_range(0, 3));
      freq_word = PW'($urandom);
      get_sample("rnd", FL, -1);
    end

    freq_word = '0;
    wave_sel = 2'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) get_sample("fw0", FL, -1);

    do_reset(2'd0, 16'hFFFF);
    get_sample("wrap0", UA + 1, 8'h00);
    for (int i = 0; i < 4; i++) get_sample("wrap", FL, 8'hFF);

    do_reset(2'd3, 16'h0100);
    for (int i = 0; i < 256; i++)
      get_sample("sin_sweep", (i == 0) ? UA + 1 : FL, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
